sdf_r2_stage_ctrl: RTL and testbench
====================================

// Module: sdf_r2_stage_ctrl
// PURPOSE
//  Sequencing and storage half of a radix-2 single-delay-feedback (SDF) FFT stage: drives the 2-bit
//  butterfly state code, holds the butterfly's SR output for DEPTH accepted cycles and returns it as B,
//  and issues the twiddle index used for the W_N^k lookup. It sits beside the combinational butterfly;
//  one instance per pipeline stage, input A stream in natural order, continuous while in_valid high.
// PARAMETERS
//  DEPTH    16   delay-line length = N/2 of this stage (power of 2, >=2)
//  CNT_W    4    log2(DEPTH); width of sample counter and wn_idx
//  DW       12   width of each real/imag delay-line word (signed, 6 int / 6 frac)
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      A sample present at butterfly input this cycle
//  sr_r       in   DW     butterfly SR output, real (value to store)
//  sr_i       in   DW     butterfly SR output, imag
//  state      out  2      to butterfly: 00 IDLE, 01 FIRST, 10 SECOND, 11 WAITING
//  b_r        out  DW     delay-line tail, real (butterfly B input)
//  b_i        out  DW     delay-line tail, imag
//  wn_idx     out  CNT_W  twiddle exponent k for W_N^k; valid in SECOND, else 0
//  out_valid  out  1      butterfly out_r/out_i is a valid result this cycle
//  frame_done out  1      one-cycle pulse on last SECOND cycle of a frame
//  err        out  1      sticky protocol-violation flag
// BEHAVIOUR
//  - Reset (async, rst_n=0): state reg IDLE, cnt 0, all delay entries 0, cont flag 0, err 0;
//    outputs state=00, b=0, wn_idx=0, out_valid=0, frame_done=0 while held.
//  - adv (shift enable): in_valid in WAITING/FIRST; always 1 in SECOND; 0 in IDLE.
//    On adv: delay line shifts in {sr_r,sr_i}, cnt increments mod DEPTH. No adv: everything holds.
//  - state output = WAITING when reg is IDLE and in_valid=1 (zero-bubble start: that sample is
//    stored, cnt->1, reg->WAITING); otherwise state output = state reg.
//  - Transitions, taken when adv and cnt==DEPTH-1:
//    WAITING->FIRST; FIRST->SECOND; SECOND->FIRST if cont=1, SECOND->IDLE if cont=0.
//  - cont: on first SECOND cycle (cnt==0) cont<=in_valid. cont=1 => next frame's first half is being
//    loaded and in_valid must stay 1 for all of SECOND; any in_valid=0 with cont=1 sets err (sticky,
//    cleared by reset only); sequencing continues unchanged. cont=0 => drain: in_valid ignored.
//  - b_r/b_i = delay-line tail, registered (sample stored DEPTH adv-cycles earlier). Stored words
//    are DW bits as given; no rounding or saturation in this block.
//  - wn_idx = cnt in SECOND, 0 otherwise. out_valid = (state==FIRST & in_valid) | (state==SECOND).
//  - frame_done = (state==SECOND) & (cnt==DEPTH-1).
//  - Latency: first valid result DEPTH accepted samples after start; frame of 2*DEPTH inputs yields
//    2*DEPTH outputs (DEPTH in FIRST, DEPTH in SECOND).
//  - Stalls (in_valid=0) in WAITING/FIRST freeze cnt, state and delay line; out_valid=0.
//  - rst_n assertion mid-frame aborts immediately; no partial output; next in_valid restarts cleanly.
// TESTING
//  1 Reset: rst_n=0 any time -> state=00, b=0, wn_idx=0, out_valid=0, err=0 asynchronously.
//  2 DEPTH=16, 32 samples A=k (k=0..31) continuous then in_valid=0 -> state 11x16, 01x16 with
//    b=k-16 on FIRST cycle k, then 10x16 with wn_idx 0..15, frame_done at cycle 47, then 00.
//  3 Stall 3 cycles at WAITING cnt=5 -> state/cnt/b frozen, out_valid=0; resume continues at cnt=5.
//  4 64 continuous samples -> SECOND goes directly to FIRST (no IDLE), frame_done at cycles 47, 79.
//  5 in_valid high at SECOND cnt=0, low at cnt=7 -> err=1 and stays 1, drain completes, err held
//    after return to IDLE until reset.
//  6 rst_n pulse during FIRST cnt=9 -> outputs zero at once; restart with 32 samples matches test 2.

Source files
------------

// File: rtl/sdf_r2_stage_ctrl.sv
// Control and delay-line storage for one radix-2 SDF FFT stage: sequences the butterfly
// state code, recirculates SR outputs as B after DEPTH advances, and issues twiddle exponents.
module sdf_r2_stage_ctrl #(
   parameter int DEPTH = 16,
   parameter int CNT_W = 4,
   parameter int DW    = 12
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [DW-1:0]    sr_r,
   input  logic [DW-1:0]    sr_i,
   output logic [1:0]       state,
   output logic [DW-1:0]    b_r,
   output logic [DW-1:0]    b_i,
   output logic [CNT_W-1:0] wn_idx,
   output logic             out_valid,
   output logic             frame_done,
   output logic             err
);

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      FIRST   = 2'b01,
      SECOND  = 2'b10,
      WAITING = 2'b11
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);

   state_t           state_r;
   state_t           state_s;
   logic [CNT_W-1:0] cnt_r;
   logic             cont_r;
   logic             err_r;
   logic             adv_s;
   logic [2*DW-1:0]  line_r [DEPTH];

   // Effective state: an IDLE stage that sees a sample behaves as WAITING in that same cycle.
   always_comb begin
      state_s = state_r;
      if (state_r == IDLE && in_valid && rst_n) begin
         state_s = WAITING;
      end else begin
         state_s = state_r;
      end
   end

   // Shift enable: the SECOND half always advances, loading and waiting halves follow in_valid.
   always_comb begin
      adv_s = 1'b0;
      case (state_s)
         WAITING, FIRST: adv_s = in_valid;
         SECOND:         adv_s = 1'b1;
         default:        adv_s = 1'b0;
      endcase
   end

   // Sequencer, sample counter, continuation/error flags and delay line.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         cnt_r   <= {CNT_W{1'b0}};
         cont_r  <= 1'b0;
         err_r   <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            line_r[i] <= {(2*DW){1'b0}};
         end
      end else begin
         if (adv_s) begin
            cnt_r     <= cnt_r + CNT_W'(1);
            line_r[0] <= {sr_r, sr_i};
            for (int i = 1; i < DEPTH; i++) begin
               line_r[i] <= line_r[i-1];
            end
            if (cnt_r == CNT_LAST) begin
               case (state_s)
                  WAITING: state_r <= FIRST;
                  FIRST:   state_r <= SECOND;
                  SECOND:  state_r <= cont_r ? FIRST : IDLE;
                  default: state_r <= IDLE;
               endcase
            end else begin
               state_r <= state_s;
            end
         end
         // cont is latched at the start of SECOND; a gap afterwards while reloading is a violation.
         if (state_s == SECOND) begin
            if (cnt_r == {CNT_W{1'b0}}) begin
               cont_r <= in_valid;
            end else if (cont_r && !in_valid) begin
               err_r <= 1'b1;
            end
         end
      end
   end

   // Output decode.
   always_comb begin
      state      = state_s;
      b_r        = line_r[DEPTH-1][2*DW-1:DW];
      b_i        = line_r[DEPTH-1][DW-1:0];
      wn_idx     = {CNT_W{1'b0}};
      out_valid  = 1'b0;
      frame_done = 1'b0;
      err        = err_r;
      if (state_s == SECOND) begin
         wn_idx     = cnt_r;
         out_valid  = 1'b1;
         frame_done = (cnt_r == CNT_LAST);
      end else begin
         out_valid  = (state_s == FIRST) && in_valid;
      end
   end

endmodule

// File: tb/tb_sdf_r2_stage_ctrl.sv
// Self-checking bench for sdf_r2_stage_ctrl (DEPTH=16): per-cycle expectations derived from the
// frame timeline are queued as stimulus is driven and compared by a negedge scoreboard.
module tb_sdf_r2_stage_ctrl;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [11:0] sr_r;
   logic [11:0] sr_i;
   logic [1:0]  state;
   logic [11:0] b_r;
   logic [11:0] b_i;
   logic [3:0]  wn_idx;
   logic        out_valid;
   logic        frame_done;
   logic        err;

   typedef struct packed {
      logic [1:0]  st;
      logic [11:0] br;
      logic [11:0] bi;
      logic [3:0]  wn;
      logic        ov;
      logic        fd;
      logic        er;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   checks;
   int   errors;
   int   cyc_no;

   sdf_r2_stage_ctrl #(.DEPTH(16), .CNT_W(4), .DW(12)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .sr_r(sr_r), .sr_i(sr_i),
      .state(state), .b_r(b_r), .b_i(b_i), .wn_idx(wn_idx), .out_valid(out_valid),
      .frame_done(frame_done), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard: one queued expectation per driven cycle, compared mid-cycle.
   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         mon_e = sb_q.pop_front();
         checks++;
         if ({state, b_r, b_i, wn_idx, out_valid, frame_done, err} !== mon_e) begin
            errors++;
            $display("FAIL stream cyc%0d: got st=%0d b=%h/%h wn=%0d ov=%b fd=%b err=%b, expected st=%0d b=%h/%h wn=%0d ov=%b fd=%b err=%b",
                     cyc_no, state, b_r, b_i, wn_idx, out_valid, frame_done, err,
                     mon_e.st, mon_e.br, mon_e.bi, mon_e.wn, mon_e.ov, mon_e.fd, mon_e.er);
         end
      end
   end

   task automatic do_reset();
      in_valid = 1'b0;
      rst_n    = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Drive one stream; j counts accepted (advancing) cycles and every stored word equals its j.
   task automatic run_stream(input int frames, input int stall_j, input int stall_len,
                             input int glitch_j, input int stop_j, input int idle_cycles);
      int   j;
      int   stalls;
      int   idle;
      int   total;
      int   q;
      logic stall;
      logic iv;
      exp_t e;
      j      = 0;
      stalls = 0;
      idle   = 0;
      total  = 32 * frames + 16;
      for (int cyc = 0; cyc < 1000; cyc++) begin
         @(posedge clk);
         #1;
         cyc_no   = cyc;
         stall    = (j == stall_j) && (stalls < stall_len);
         iv       = (j < 32 * frames) && !stall && (j != glitch_j);
         in_valid = iv;
         sr_r     = stall ? 12'h5A5 : 12'(j);
         sr_i     = stall ? 12'hA5A : 12'(-j);
         q        = j / 16;
         e.er     = (glitch_j >= 0) && (j > glitch_j);
         if (j >= total) begin
            e.st = 2'd0; e.br = 12'(total - 16); e.bi = 12'(16 - total);
            e.wn = 4'd0; e.ov = 1'b0; e.fd = 1'b0;
         end else if (q == 0) begin
            e.st = 2'd3; e.br = 12'd0; e.bi = 12'd0;
            e.wn = 4'd0; e.ov = 1'b0; e.fd = 1'b0;
         end else if (q % 2 == 1) begin
            e.st = 2'd1; e.br = 12'(j - 16); e.bi = 12'(16 - j);
            e.wn = 4'd0; e.ov = iv; e.fd = 1'b0;
         end else begin
            e.st = 2'd2; e.br = 12'(j - 16); e.bi = 12'(16 - j);
            e.wn = 4'(j % 16); e.ov = 1'b1; e.fd = (j % 16 == 15);
         end
         sb_q.push_back(e);
         @(negedge clk);
         if (stop_j >= 0 && j == stop_j) break;
         if (stall) stalls++;
         else if (j < total) j++;
         else idle++;
         if (j >= total && idle >= idle_cycles) break;
      end
      #1;
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n    = 1'b0;
      in_valid = 1'b1;
      sr_r     = 12'h123;
      sr_i     = 12'h456;
      #3;
      checks++;
      if ({state, b_r, b_i, wn_idx, out_valid, frame_done, err} !== 33'd0) begin
         errors++;
         $display("FAIL reset_state: got st=%0d b=%h/%h wn=%0d ov=%b fd=%b err=%b, expected all zero",
                  state, b_r, b_i, wn_idx, out_valid, frame_done, err);
      end
      do_reset();
   endtask

   task automatic test_single_frame();
      do_reset();
      run_stream(1, -1, 0, -1, -1, 4);
   endtask

   task automatic test_stall();
      do_reset();
      run_stream(1, 5, 3, -1, -1, 2);
   endtask

   task automatic test_back_to_back();
      do_reset();
      run_stream(2, -1, 0, -1, -1, 3);
   endtask

   task automatic test_protocol_err();
      do_reset();
      run_stream(2, -1, 0, 39, -1, 4);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (err !== 1'b0) begin
         errors++;
         $display("FAIL err_clear: got err=%b, expected 0", err);
      end
      do_reset();
   endtask

   task automatic test_midframe_reset();
      do_reset();
      run_stream(1, -1, 0, -1, 25, 0);
      in_valid = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({state, b_r, b_i, wn_idx, out_valid, frame_done, err} !== 33'd0) begin
         errors++;
         $display("FAIL abort_reset: got st=%0d b=%h/%h wn=%0d ov=%b fd=%b err=%b, expected all zero",
                  state, b_r, b_i, wn_idx, out_valid, frame_done, err);
      end
      do_reset();
      run_stream(1, -1, 0, -1, -1, 3);
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      cyc_no   = 0;
      in_valid = 1'b0;
      sr_r     = 12'd0;
      sr_i     = 12'd0;
      rst_n    = 1'b0;
      test_reset();
      test_single_frame();
      test_stall();
      test_back_to_back();
      test_protocol_err();
      test_midframe_reset();
      repeat (2) @(posedge clk);
      checks++;
      if (sb_q.size() !== 0) begin
         errors++;
         $display("FAIL sb_drain: got %0d pending entries, expected 0", sb_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
